writeback_regfile: RTL and testbench
====================================

// Module: writeback_regfile
// PURPOSE
// Write-back stage and architectural register file of the sequential Y86-64 core.
// Takes the retiring instruction's fields and results (valE from execute, valM from memory) and writes r0..r14 on the clock edge.
// Exposes all 15 registers as outputs that feed decode's r0..r14 read ports. This block is the writer for decode's reader.
// Also latches a sticky halted status and counts retired instructions.
// PARAMETERS
// WIDTH     64     register and data width in bits
// RSP_INIT  64'd0  reset value of r4 (%rsp); every other register resets to 0
// PORTS
// clk       in   1      clock; all state updates on posedge
// rst       in   1      asynchronous, active-high reset
// wb_valid  in   1      an instruction retires at this posedge
// icode     in   4      instruction code of the retiring instruction
// rA        in   4      rA field; 4'hF = no register
// rB        in   4      rB field; 4'hF = no register
// cond      in   1      condition result from execute (used by cmovXX only)
// valE      in   WIDTH  execute result
// valM      in   WIDTH  memory read result
// in_mem    in   1      memory address error on this instruction
// in_inst   in   1      invalid instruction on this instruction
// hlt       in   1      halt instruction retiring
// r0..r14   out  WIDTH  current register contents, registered outputs (15 ports)
// halted    out  1      sticky: core has stopped and no further writes are accepted
// retired   out  32     count of instructions retired without fault
// BEHAVIOUR
// - Reset (async, takes effect immediately, including mid-write): r0..r14=0, r4=RSP_INIT, halted=0, retired=0.
// - dstE (combinational): icode 2 -> rB if cond, else F. Icode 3 or 6 -> rB. Icode 8, 9, A or B -> 4. All other icodes -> F.
// - dstM (combinational): icode 5 or B -> rA; all other icodes -> F.
// - A posedge commits only when wb_valid=1 and halted=0. Otherwise no state changes.
// - Commit with any of hlt/in_mem/in_inst =1:
//   - no register write; halted<=1; retired unchanged.
// - Normal commit, hlt, in_mem and in_inst all 0:
//   - if dstE!=F, R[dstE]<=valE. If dstM!=F, R[dstM]<=valM.
//   - if dstE==dstM!=F (popq %rsp), valM wins.
//   - retired<=retired+1, wrapping at 2^32-1 -> 0.
// - Writes take effect at the posedge; outputs show the new values after it. There is no write-to-read bypass.
// - Register index F never writes. Invalid icodes (>B) give dstE=dstM=F; their status arrives via in_inst.
// - Only reset clears halted.
// - valE and valM are stored unmodified as WIDTH-bit two's-complement values.
// TESTING
// - Reset with RSP_INIT=64'h100: all r*=0 except r4=0x100; halted=0, retired=0.
// - irmovq $10,%rdx (icode3,rA=F,rB=2,valE=10), wb_valid=1 -> r2=10, retired=1.
// - cmovXX with cond=0 (rA=2,rB=3,valE=10) -> r3 unchanged. Repeat with cond=1 -> r3=10.
// - mrmovq (icode5,rA=1,valM=0xDEAD) -> r1=0xDEAD. popq %rsp (icode B,rA=4,valE=0x108,valM=0x55) -> r4=0x55.
// - hlt=1 commit -> halted=1, no write. Then OPq (icode6,rB=0,valE=7) -> r0 unchanged, retired unchanged.
// - Assert rst mid-cycle after several writes: outputs zero immediately with no clock edge. Preset retired=32'hFFFFFFFF, then retire one -> retired=0.

Source files
------------

// File: rtl/writeback_regfile.sv
// Write-back stage and architectural register file of the sequential Y86-64 core.
// Commits valE/valM of the retiring instruction to r0..r14, latches halt status and counts retirements.
module writeback_regfile #(
   parameter int                 WIDTH    = 64,
   parameter logic [WIDTH-1:0]   RSP_INIT = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wb_valid,
   input  logic [3:0]       icode,
   input  logic [3:0]       rA,
   input  logic [3:0]       rB,
   input  logic             cond,
   input  logic [WIDTH-1:0] valE,
   input  logic [WIDTH-1:0] valM,
   input  logic             in_mem,
   input  logic             in_inst,
   input  logic             hlt,
   output logic [WIDTH-1:0] r0,
   output logic [WIDTH-1:0] r1,
   output logic [WIDTH-1:0] r2,
   output logic [WIDTH-1:0] r3,
   output logic [WIDTH-1:0] r4,
   output logic [WIDTH-1:0] r5,
   output logic [WIDTH-1:0] r6,
   output logic [WIDTH-1:0] r7,
   output logic [WIDTH-1:0] r8,
   output logic [WIDTH-1:0] r9,
   output logic [WIDTH-1:0] r10,
   output logic [WIDTH-1:0] r11,
   output logic [WIDTH-1:0] r12,
   output logic [WIDTH-1:0] r13,
   output logic [WIDTH-1:0] r14,
   output logic             halted,
   output logic [31:0]      retired
);

   typedef enum logic [3:0] {
      I_HALT  = 4'h0, I_NOP  = 4'h1, I_CMOV = 4'h2, I_IRMOV = 4'h3,
      I_RMMOV = 4'h4, I_MRMOV = 4'h5, I_OP  = 4'h6, I_JXX  = 4'h7,
      I_CALL  = 4'h8, I_RET  = 4'h9, I_PUSH = 4'hA, I_POP  = 4'hB
   } icode_e;

   localparam logic [3:0] R_NONE = 4'hF;
   localparam logic [3:0] R_RSP  = 4'h4;

   logic [WIDTH-1:0] r_regs [0:14];
   logic             r_halted;
   logic [31:0]      r_retired;

   logic [3:0]       w_dst_e;
   logic [3:0]       w_dst_m;
   logic             w_commit;
   logic             w_fault;

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      w_dst_e = R_NONE;
      w_dst_m = R_NONE;
      case (icode)
         I_CMOV:                       if (cond) w_dst_e = rB;
         I_IRMOV, I_OP:                w_dst_e = rB;
         I_CALL, I_RET, I_PUSH, I_POP: w_dst_e = R_RSP;
         default:                      ;
      endcase
      if (icode == I_MRMOV || icode == I_POP) w_dst_m = rA;
   end

   assign w_commit = wb_valid & ~r_halted;
   assign w_fault  = hlt | in_mem | in_inst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the register file is reset element by element because decode reads it
         // straight after reset and %rsp needs its own initial value.
         for (int i = 0; i < 15; i++) begin
            r_regs[i] <= (i == 4) ? RSP_INIT : '0;
         end
         r_halted  <= 1'b0;
         r_retired <= '0;
      end else if (w_commit) begin
         if (w_fault) begin
            // NOTE: non-blocking assignments keep every state update tied to the same edge.
            r_halted <= 1'b1;
         end else begin
            if (w_dst_e != R_NONE) r_regs[w_dst_e] <= valE;
            // Last assignment wins, so popq %rsp leaves valM in r4.
            if (w_dst_m != R_NONE) r_regs[w_dst_m] <= valM;
            r_retired <= r_retired + 32'd1;
         end
      end
   end

   assign r0      = r_regs[0];
   assign r1      = r_regs[1];
   assign r2      = r_regs[2];
   assign r3      = r_regs[3];
   assign r4      = r_regs[4];
   assign r5      = r_regs[5];
   assign r6      = r_regs[6];
   assign r7      = r_regs[7];
   assign r8      = r_regs[8];
   assign r9      = r_regs[9];
   assign r10     = r_regs[10];
   assign r11     = r_regs[11];
   assign r12     = r_regs[12];
   assign r13     = r_regs[13];
   assign r14     = r_regs[14];
   assign halted  = r_halted;
   assign retired = r_retired;

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: stimulus pushes hand-computed expected state,
// a monitor compares it one cycle later, after the committing edge.
module tb_writeback_regfile;

   localparam int          W   = 64;
   localparam logic [63:0] RSP = 64'h100;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [3:0]  icode, rA, rB;
   logic        cond, in_mem, in_inst, hlt;
   logic [63:0] valE, valM;
   logic [63:0] dr [15];
   logic        halted;
   logic [31:0] retired;

   writeback_regfile #(.WIDTH(W), .RSP_INIT(RSP)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
      .cond(cond), .valE(valE), .valM(valM), .in_mem(in_mem), .in_inst(in_inst), .hlt(hlt),
      .r0(dr[0]), .r1(dr[1]), .r2(dr[2]), .r3(dr[3]), .r4(dr[4]), .r5(dr[5]), .r6(dr[6]),
      .r7(dr[7]), .r8(dr[8]), .r9(dr[9]), .r10(dr[10]), .r11(dr[11]), .r12(dr[12]),
      .r13(dr[13]), .r14(dr[14]), .halted(halted), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15*64-1:0] regs;
      logic             halted;
      logic [31:0]      retired;
      int               due;
      string            tag;
   } exp_t;

   exp_t        q[$];
   int          cyc      = 0;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [63:0] m [15];
   logic        m_h;
   logic [31:0] m_ret;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic compare(exp_t e);
      for (int i = 0; i < 15; i++)
         check($sformatf("%s r%0d", e.tag, i), dr[i], e.regs[i*64 +: 64]);
      check({e.tag, " halted"}, {63'b0, halted}, {63'b0, e.halted});
      check({e.tag, " retired"}, {32'b0, retired}, {32'b0, e.retired});
   endtask

   function automatic exp_t snap(string tag, int due);
      exp_t e;
      for (int i = 0; i < 15; i++) e.regs[i*64 +: 64] = m[i];
      e.halted  = m_h;
      e.retired = m_ret;
      e.due     = due;
      e.tag     = tag;
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 15; i++) m[i] = '0;
      m[4]  = RSP;
      m_h   = 1'b0;
      m_ret = '0;
   endtask

   // Drive one retiring instruction; called just after a negedge.
   task automatic issue(logic [3:0] ic, logic [3:0] a, logic [3:0] b, logic c,
                        logic [63:0] e, logic [63:0] mm, logic f_hlt, logic f_mem, logic f_inst);
      wb_valid = 1'b1;
      icode = ic; rA = a; rB = b; cond = c; valE = e; valM = mm;
      hlt = f_hlt; in_mem = f_mem; in_inst = f_inst;
   endtask

   // Queue the model state as the expectation after the next posedge, then let that edge pass.
   task automatic commit(string tag);
      q.push_back(snap(tag, cyc + 1));
      @(negedge clk);
      wb_valid = 1'b0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            compare(e);
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF; cond = 1'b0;
      valE = '0; valM = '0; in_mem = 1'b0; in_inst = 1'b0; hlt = 1'b0;
      model_reset();
      #2;
      compare(snap("reset", 0));
      @(negedge clk);
      rst = 1'b0;

      issue(4'h3, 4'hF, 4'h2, 1'b0, 64'd10, 64'd0, 0, 0, 0);
      m[2] = 64'd10; m_ret = 1; commit("irmovq");

      issue(4'h2, 4'h2, 4'h3, 1'b0, 64'd10, 64'd0, 0, 0, 0);
      m_ret = 2; commit("cmov_nt");

      issue(4'h2, 4'h2, 4'h3, 1'b1, 64'd10, 64'd0, 0, 0, 0);
      m[3] = 64'd10; m_ret = 3; commit("cmov_t");

      issue(4'h5, 4'h1, 4'h0, 1'b0, 64'h20, 64'hDEAD, 0, 0, 0);
      m[1] = 64'hDEAD; m_ret = 4; commit("mrmovq");

      issue(4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'h55, 0, 0, 0);
      m[4] = 64'h55; m_ret = 5; commit("popq_rsp");

      issue(4'hA, 4'h7, 4'hF, 1'b0, 64'hF8, 64'h0, 0, 0, 0);
      m[4] = 64'hF8; m_ret = 6; commit("pushq");

      issue(4'h6, 4'h3, 4'h5, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 0, 0);
      m[5] = 64'hFFFF_FFFF_FFFF_FFFF; m_ret = 7; commit("opq_neg");

      issue(4'h3, 4'hF, 4'h6, 1'b0, 64'd99, 64'd0, 0, 0, 0);
      wb_valid = 1'b0;
      commit("no_valid");

      issue(4'hC, 4'h7, 4'h7, 1'b1, 64'd1, 64'd2, 0, 0, 0);
      m_ret = 8; commit("bad_icode");

      issue(4'h5, 4'hF, 4'h0, 1'b0, 64'd0, 64'h77, 0, 0, 0);
      m_ret = 9; commit("mrmov_rF");

      issue(4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1, 0, 0);
      m_h = 1'b1; commit("hlt");

      issue(4'h6, 4'h1, 4'h0, 1'b0, 64'd7, 64'd0, 0, 0, 0);
      commit("after_hlt");

      // Asynchronous reset between edges: outputs clear with no clock edge.
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      compare(snap("async_rst", 0));
      @(negedge clk);
      rst = 1'b0;

      issue(4'h3, 4'hF, 4'h2, 1'b0, 64'd5, 64'd0, 0, 1, 0);
      m_h = 1'b1; commit("in_mem");

      @(negedge clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
      model_reset();

      // Preset the retire counter to its last value to exercise the wrap.
      force dut.r_retired = 32'hFFFF_FFFF;
      #1;
      release dut.r_retired;
      check("preset retired", {32'b0, retired}, 64'hFFFF_FFFF);
      issue(4'h3, 4'hF, 4'h9, 1'b0, 64'd3, 64'd0, 0, 0, 0);
      m[9] = 64'd3; m_ret = 32'd0; commit("wrap");

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      check("scoreboard drained", 64'(q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
